// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : lsu_pkg                                                         |
// | Purpose  : Shared types and helpers for the load/store memory master:      |
// |            FSM state encoding, access-size codes, word-crossing detection  |
// |            and byte-lane mask generation.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR0  = 3'd3,
    ST_WR1  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  // Access size codes, funct3[1:0]. Code 3 is folded into SZ_W at capture.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // True when the access spills into the next word.
  function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && (off == 2'd3)) ||
           ((size == SZ_W) && (off != 2'd0));
  endfunction

  // Byte lanes touched by an access of the given size at offset 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_master_align.sv
// +----------------------------------------------------------------------------+
// | Module   : lsu_align                                                       |
// | Purpose  : Combinational data alignment for the load/store master.         |
// |            Extracts and extends load data from a two-word window and       |
// |            merges store data into the old contents of both words.          |
// | Ports    : lo_word/hi_word - word at w0 / word at w0+1                     |
// |            wdata           - right-aligned store data                      |
// |            off, size, uns  - byte offset, size code, unsigned-load flag    |
// |            load_data       - extracted, extended load result               |
// |            word0/word1     - merged store words for w0 / w0+1              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] load_data,
  output logic [31:0] word0,
  output logic [31:0] word1
);

  logic [31:0] w_shift;
  logic [63:0] w_data_sh;
  logic [7:0]  w_lanes;
  logic [63:0] w_bitmask;

  // Little-endian window: the addressed byte lands in bit 0.
  assign w_shift = 32'({hi_word, lo_word} >> {off, 3'b000});

  always_comb begin
    load_data = w_shift;
    case (size)
      SZ_B:    load_data = {{24{~uns & w_shift[7]}}, w_shift[7:0]};
      SZ_H:    load_data = {{16{~uns & w_shift[15]}}, w_shift[15:0]};
      default: load_data = w_shift;
    endcase
  end

  // Lanes beyond the access size are masked off, so upper store-data bits
  // never leak into memory.
  assign w_data_sh = {32'd0, wdata} << {off, 3'b000};
  assign w_lanes   = {4'b0000, lane_mask(size)} << off;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign w_bitmask[i*8 +: 8] = {8{w_lanes[i]}};
  end

  assign word0 = (lo_word & ~w_bitmask[31:0])  | (w_data_sh[31:0]  & w_bitmask[31:0]);
  assign word1 = (hi_word & ~w_bitmask[63:32]) | (w_data_sh[63:32] & w_bitmask[63:32]);

endmodule

`default_nettype wire

// File: rtl/lsu_mem_master.sv
// +----------------------------------------------------------------------------+
// | Module   : lsu_mem_master                                                  |
// | Purpose  : Load/store initiator between execute and a word-organised data  |
// |            memory. Sub-word stores become read-modify-write; accesses that |
// |            cross a word boundary are split into two word accesses.         |
// | Ports    : clk, rst (sync, active high)                                    |
// |            req_*  - request handshake, address, funct3 width, store data   |
// |            resp_* - single-cycle completion with load data / error flag    |
// |            mem_*  - word address, write enable, write data, comb. read     |
// | Config   : MISALIGN_TRAP_EN - when defined, crossing requests skip memory  |
// |            and complete with resp_err=1. Undefined: they are split.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int N  = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [DW-1:0] req_addr,
  input  logic [2:0]    req_width,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [N-1:0]  mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_q, state_d;
  logic [N-1:0]  w0_q, w0_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          we_q, we_d;
  logic          cross_q, cross_d;
  logic          trap_pend_q, trap_pend_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [N-1:0]  mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]    w_req_size;
  logic          w_req_cross;
  logic          w_trap;
  logic [DW-1:0] w_lo, w_hi, w_ld_data, w_word0, w_word1;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[DW-1:N+2];

  assign w_req_size  = (req_width[1:0] == 2'd3) ? SZ_W : req_width[1:0];
  assign w_req_cross = crosses(w_req_size, req_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign w_trap = w_req_cross;
`else
  assign w_trap = 1'b0;
`endif

  // The word being read this cycle comes straight from memory; the other
  // half of the window comes from the buffer captured earlier.
  assign w_lo = (state_q == ST_RD0) ? mem_rdata : buf0_q;
  assign w_hi = (state_q == ST_RD1) ? mem_rdata : buf1_q;

  lsu_align u_align (
    .lo_word   (w_lo),
    .hi_word   (w_hi),
    .wdata     (wdata_q),
    .off       (off_q),
    .size      (size_q),
    .uns       (uns_q),
    .load_data (w_ld_data),
    .word0     (w_word0),
    .word1     (w_word1)
  );

  always_comb begin
    state_d      = state_q;
    w0_d         = w0_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    cross_d      = cross_q;
    trap_pend_d  = trap_pend_q;
    wdata_d      = wdata_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          w0_d    = req_addr[N+1:2];
          off_d   = req_addr[1:0];
          size_d  = w_req_size;
          uns_d   = req_width[2];
          we_d    = req_we;
          cross_d = w_req_cross;
          wdata_d = req_wdata;
          if (w_trap) begin
            // Hold RESP one extra cycle so the error lands at T+2.
            state_d     = ST_RESP;
            trap_pend_d = 1'b1;
          end else if (req_we && (w_req_size == SZ_W) && (req_addr[1:0] == 2'd0)) begin
            state_d     = ST_WR0;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = ST_RD0;
          end
        end
      end
      ST_RD0: begin
        buf0_d = mem_rdata;
        if (we_q) begin
          state_d     = ST_WR0;
          mem_wdata_d = w_word0;
        end else if (cross_q) begin
          state_d = ST_RD1;
        end else begin
          state_d      = ST_RESP;
          resp_rdata_d = w_ld_data;
        end
      end
      ST_WR0: state_d = cross_q ? ST_RD1 : ST_RESP;
      ST_RD1: begin
        buf1_d = mem_rdata;
        if (we_q) begin
          state_d     = ST_WR1;
          mem_wdata_d = w_word1;
        end else begin
          state_d      = ST_RESP;
          resp_rdata_d = w_ld_data;
        end
      end
      ST_WR1: state_d = ST_RESP;
      ST_RESP: begin
        if (trap_pend_q) begin
          trap_pend_d = 1'b0;
          resp_err_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP) && !trap_pend_d;
    mem_we_d     = (state_d == ST_WR0) || (state_d == ST_WR1);
    mem_addr_d   = ((state_d == ST_RD1) || (state_d == ST_WR1)) ? (w0_d + N'(1)) : w0_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      w0_q         <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      cross_q      <= 1'b0;
      trap_pend_q  <= 1'b0;
      wdata_q      <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      w0_q         <= w0_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      cross_q      <= cross_d;
      trap_pend_q  <= trap_pend_d;
      wdata_q      <= wdata_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  // A reset asserted during a write cycle must not commit that write.
  assign mem_we     = mem_we_q & ~rst;

endmodule

`default_nettype wire
